collision_pair_scheduler: RTL and testbench

COLLISION_PAIR_SCHEDULER -- requirements
Module: collision_pair_scheduler

---
 rtl/collision_pair_scheduler.sv | 162 ++++++++++++++++
 tb/tb_collision_pair_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/collision_pair_scheduler.sv
// rtl/collision_pair_scheduler.sv - streams every unordered object pair (i<j) from object memory to a collision unit.
// Defining PAIR_COUNT_EN adds a saturating 16-bit pair_count output.
module collision_pair_scheduler #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_objects,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pair_a,
  output logic [DATA_W-1:0] pair_b,
  output logic [ADDR_W-1:0] pair_idx_a,
  output logic [ADDR_W-1:0] pair_idx_b,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic              busy,
  output logic              done
`ifdef PAIR_COUNT_EN
  ,
  output logic [15:0]       pair_count
`endif
);

  typedef enum logic [2:0] {
    IDLE, RD_A, CAP_A, RD_B, CAP_B, PRESENT, FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [DATA_W-1:0] pair_a_q, pair_a_d;
  logic [DATA_W-1:0] pair_b_q, pair_b_d;
  logic [ADDR_W-1:0] idx_a_q, idx_a_d;
  logic [ADDR_W-1:0] idx_b_q, idx_b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       cnt_q, cnt_d;

  // One extra bit so j+1 and i+2 never wrap before comparing against N.
  logic [ADDR_W:0]   j_inc, i_inc2, n_ext;

  assign j_inc  = {1'b0, j_q} + (ADDR_W+1)'(1);
  assign i_inc2 = {1'b0, i_q} + (ADDR_W+1)'(2);
  assign n_ext  = {1'b0, n_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      pair_a_q <= '0;
      pair_b_q <= '0;
      idx_a_q  <= '0;
      idx_b_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      i_q      <= i_d;
      j_q      <= j_d;
      pair_a_q <= pair_a_d;
      pair_b_q <= pair_b_d;
      idx_a_q  <= idx_a_d;
      idx_b_q  <= idx_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    i_d      = i_q;
    j_d      = j_q;
    pair_a_d = pair_a_q;
    pair_b_d = pair_b_q;
    idx_a_d  = idx_a_q;
    idx_b_d  = idx_b_q;
    busy_d   = busy_q;
    done_d   = done_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          done_d = 1'b0;
          n_d    = num_objects;
          cnt_d  = '0;
          if (num_objects >= ADDR_W'(2)) begin
            i_d     = '0;
            j_d     = ADDR_W'(1);
            busy_d  = 1'b1;
            state_d = RD_A;
          end else begin
            state_d = FINISH;
          end
        end
      end
      RD_A:  state_d = CAP_A;
      CAP_A: begin
        pair_a_d = mem_rdata;
        idx_a_d  = i_q;
        state_d  = RD_B;
      end
      RD_B:  state_d = CAP_B;
      CAP_B: begin
        pair_b_d = mem_rdata;
        idx_b_d  = j_q;
        state_d  = PRESENT;
      end
      PRESENT: begin
        if (pair_ready) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (j_inc < n_ext) begin
            j_d     = j_inc[ADDR_W-1:0];
            state_d = RD_B;
          end else if (i_inc2 < n_ext) begin
            i_d     = i_q + ADDR_W'(1);
            j_d     = i_inc2[ADDR_W-1:0];
            state_d = RD_A;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_rd_en  = (state_q == RD_A) || (state_q == RD_B);
  assign mem_addr   = (state_q == RD_A) ? i_q :
                      (state_q == RD_B) ? j_q : '0;
  assign pair_valid = (state_q == PRESENT);
  assign pair_a     = pair_a_q;
  assign pair_b     = pair_b_q;
  assign pair_idx_a = idx_a_q;
  assign pair_idx_b = idx_b_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef PAIR_COUNT_EN
  assign pair_count = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt_q;
`endif

endmodule

// File: tb/tb_collision_pair_scheduler.sv
// tb/tb_collision_pair_scheduler.sv - randomized scoreboard bench for collision_pair_scheduler.
module tb_collision_pair_scheduler;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] num_objects = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] pair_a, pair_b;
  logic [AW-1:0] pair_idx_a, pair_idx_b;
  logic          pair_valid;
  logic          pair_ready = 1'b0;
  logic          busy, done;
`ifdef PAIR_COUNT_EN
  logic [15:0]   pair_count;
`endif

  collision_pair_scheduler #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_objects(num_objects),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pair_a(pair_a), .pair_b(pair_b), .pair_idx_a(pair_idx_a), .pair_idx_b(pair_idx_b),
    .pair_valid(pair_valid), .pair_ready(pair_ready), .busy(busy), .done(done)
`ifdef PAIR_COUNT_EN
    , .pair_count(pair_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            i;
    int            j;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } pair_t;

  pair_t         exp_q[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            checks = 0;
  int            failures = 0;
  int            reads = 0;
  int            ready_mode = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Synchronous-read object memory with a read counter.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
      reads++;
    end
  end

  // Ready driver: 0 = hold low, 1 = always high, 2 = random, 3 = high except on pair (1,3).
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: pair_ready = 1'b0;
        1: pair_ready = 1'b1;
        2: pair_ready = 1'($urandom_range(0, 1));
        default: pair_ready = !(pair_valid && pair_idx_a == 1 && pair_idx_b == 3);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks stall stability and re-present gaps.
  initial begin
    bit            prev_valid = 0;
    bit            stalled = 0;
    bit            track = 0;
    int            since = 0;
    int            last_i = 0;
    logic [127:0]  snap = '0;
    pair_t         e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_valid = 0; stalled = 0; track = 0;
      end else begin
        if (track) since++;
        if (pair_valid) check("no_read_while_presenting", mem_rd_en, 0);
        if (pair_valid && !prev_valid && track && exp_q.size() > 0)
          check("represent_gap", since, (exp_q[0].i == last_i) ? 3 : 5);
        if (pair_valid && !pair_ready) begin
          if (stalled) check("stall_stable", {pair_a, pair_b, pair_idx_a, pair_idx_b}, snap);
          snap = {pair_a, pair_b, pair_idx_a, pair_idx_b};
          stalled = 1;
        end else begin
          stalled = 0;
        end
        if (pair_valid && pair_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pair", {pair_idx_a, pair_idx_b}, 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            check("pair_idx_a", pair_idx_a, e.i);
            check("pair_idx_b", pair_idx_b, e.j);
            check("pair_a", pair_a, e.a);
            check("pair_b", pair_b, e.b);
            last_i = e.i;
            track = (exp_q.size() != 0);
            since = 0;
          end
        end
        prev_valid = pair_valid;
      end
    end
  end

  int base_reads;

  task automatic start_pass(input int n);
    int k;
    for (int x = 0; x < n; x++) mem[x] = $urandom;
    for (int i = 0; i < n; i++)
      for (int j = i + 1; j < n; j++)
        exp_q.push_back('{i: i, j: j, a: mem[i], b: mem[j]});
    base_reads = reads;
    @(posedge clk); #1;
    start = 1'b1; num_objects = AW'(n);
    @(posedge clk); #1;
    start = 1'b0; num_objects = AW'($urandom);
    check("done_cleared_on_start", done, 0);
    check("busy_after_start", busy, (n >= 2) ? 1 : 0);
    k = 0;
    while (k < 8 && !((n >= 2) ? pair_valid : done)) begin
      @(posedge clk); #1;
      k++;
    end
    check((n >= 2) ? "first_valid_latency" : "short_pass_done_latency", k, (n >= 2) ? 4 : 1);
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (!done && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check("done_reached", done, 1);
    check("busy_cleared", busy, 0);
    check("read_count", reads - base_reads, (n >= 2) ? (n - 1) + n * (n - 1) / 2 : 0);
    check("all_pairs_seen", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outputs_zero"},
          {mem_rd_en, mem_addr, pair_valid, busy, done, |pair_a, |pair_b, |pair_idx_a, |pair_idx_b}, 0);
`ifdef PAIR_COUNT_EN
    check({tag, "_pair_count_zero"}, pair_count, 0);
`endif
  endtask

  initial begin
    int r0, t;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("no_reads_after_reset", reads, 0);

    ready_mode = 1;
    start_pass(4);
    wait_done(4);
`ifdef PAIR_COUNT_EN
    check("pair_count_n4", pair_count, 6);
`endif

    start_pass(1); wait_done(1);
    start_pass(0); wait_done(0);

    ready_mode = 0;
    start_pass(3);
    r0 = reads;
    repeat (10) @(posedge clk);
    #1 check("stall_no_reads", reads - r0, 0);
    check("stall_still_valid", {pair_valid, pair_idx_a, pair_idx_b}, {1'b1, 8'd0, 8'd1});
    ready_mode = 1;
    wait_done(3);

    ready_mode = 3;
    start_pass(5);
    t = 0;
    while (!(pair_valid && pair_idx_a == 1 && pair_idx_b == 3) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("reached_pair_1_3", {pair_valid, pair_idx_a, pair_idx_b}, {1'b1, 8'd1, 8'd3});
    #2 rst = 1'b0;
    #1 check_all_zero("midpass_reset");
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    r0 = reads;
    repeat (6) @(posedge clk);
    #1 check("idle_after_reset", {reads - r0, 32'(pair_valid), 32'(busy)}, 0);
    ready_mode = 1;
    start_pass(2);
    wait_done(2);

    ready_mode = 2;
    start_pass(5);
    repeat (12) @(posedge clk);
    #1 start = 1'b1; num_objects = 8'd2;
    check("busy_during_stray_start", busy, 1);
    @(posedge clk); #1 start = 1'b0; num_objects = AW'($urandom);
    wait_done(5);
`ifdef PAIR_COUNT_EN
    check("pair_count_n5", pair_count, 10);
`endif

    for (int p = 0; p < 6; p++) begin
      int n = $urandom_range(0, 9);
      start_pass(n);
      wait_done(n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
